// File: rtl/mux_arb_pkg.sv
// Shared types and default sizes for the two-requester
// round-robin output arbiter.
package mux_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker: grants only when the
// output slot is free, ties go to the side that did not win last.
module arb_rr2 (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_last,
    input  logic free,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_id
);

    logic pick0;
    logic pick1;

    // Resolve the pick, then qualify it with slot availability.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        unique case (1'b1)
            (valid0 & ~valid1): pick0 = 1'b1;
            (~valid0 & valid1): pick1 = 1'b1;
            (valid0 & valid1): begin
                pick0 = rr_last;
                pick1 = ~rr_last;
            end
            default: ;
        endcase
        gnt0   = free & pick0;
        gnt1   = free & pick1;
        gnt_id = gnt1;
    end

endmodule

// File: rtl/mux21_arb.sv
// Registered 2:1 output channel shared by two valid/ready requesters.
// Optional per-requester grant counters: define MUX_ARB_STATS_EN.
module mux21_arb
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid0,
    input  logic [DATA_W-1:0] i_w0,
    output logic              o_ready0,
    input  logic              i_valid1,
    input  logic [DATA_W-1:0] i_w1,
    output logic              o_ready1,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_f,
    output logic              o_sel,
`ifdef MUX_ARB_STATS_EN
    output logic [CNT_W-1:0]  o_cnt0,
    output logic [CNT_W-1:0]  o_cnt1,
`endif
    input  logic              i_ready
);

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] f_q, f_d;
    logic              sel_q, sel_d;
    logic              rr_last_q, rr_last_d;
    logic              free;
    logic              gnt0, gnt1, gnt_id;
    logic              accept;

    // Reset forces both readies low so nothing is taken while it is held.
    assign free = (~o_valid | i_ready) & ~i_rst;

    arb_rr2 u_pick (
        .valid0  (i_valid0),
        .valid1  (i_valid1),
        .rr_last (rr_last_q),
        .free    (free),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_id  (gnt_id)
    );

    assign accept   = gnt0 | gnt1;
    assign o_ready0 = gnt0;
    assign o_ready1 = gnt1;
    assign o_valid  = (state_q == ST_BUSY);
    assign o_f      = f_q;
    assign o_sel    = sel_q;

    // Next state and next contents of the output register.
    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        sel_d     = sel_q;
        rr_last_d = rr_last_q;
        if (accept) begin
            f_d       = gnt_id ? i_w1 : i_w0;
            sel_d     = gnt_id;
            rr_last_d = gnt_id;
        end
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (i_ready && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output register; reset discards any held word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            f_q       <= '0;
            sel_q     <= 1'b0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            sel_q     <= sel_d;
            rr_last_q <= rr_last_d;
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Saturating grant counters, one per requester.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt0 && cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
        if (gnt1 && cnt1_q != '1) cnt1_d = cnt1_q + 1'b1;
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign o_cnt0 = cnt0_q;
    assign o_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mux21_arb.sv
// Directed test of the round-robin output arbiter.
// Covers reset, alternation, backpressure and mid-run reset.
module tb_mux21_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1, rdy0, rdy1;
    logic [3:0] w0, w1, f;
    logic       ov, sel, dn_rdy;
    logic [1:0] cnt0, cnt1;
    int         vecs = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    mux21_arb #(.DATA_W(4), .CNT_W(2)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid0 (v0),
        .i_w0     (w0),
        .o_ready0 (rdy0),
        .i_valid1 (v1),
        .i_w1     (w1),
        .o_ready1 (rdy1),
        .o_valid  (ov),
        .o_f      (f),
        .o_sel    (sel),
`ifdef MUX_ARB_STATS_EN
        .o_cnt0   (cnt0),
        .o_cnt1   (cnt1),
`endif
        .i_ready  (dn_rdy)
    );

`ifndef MUX_ARB_STATS_EN
    assign cnt0 = 2'd0;
    assign cnt1 = 2'd0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
        w0 = 4'b0101; w1 = 4'b1110; dn_rdy = 1'b1;

        // reset held two cycles with both valid
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_valid", 8'(ov), 8'd0);
            chk("rst_f", 8'(f), 8'd0);
            chk("rst_sel", 8'(sel), 8'd0);
            chk("rst_rdy0", 8'(rdy0), 8'd0);
            chk("rst_rdy1", 8'(rdy1), 8'd0);
        end
        rst = 1'b0;
        #1;
        chk("tie_rdy0", 8'(rdy0), 8'd1);
        chk("tie_rdy1", 8'(rdy1), 8'd0);

        // alternation with output unblocked
        step();
        for (int i = 0; i < 6; i++) begin
            chk("alt_valid", 8'(ov), 8'd1);
            chk("alt_sel", 8'(sel), 8'(i % 2));
            chk("alt_f", 8'(f), (i % 2) ? 8'h0e : 8'h05);
            if (i < 5) step();
        end

        // backpressure while holding 1110
        dn_rdy = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            w1 = 4'b0001;
            chk("bp_rdy0", 8'(rdy0), 8'd0);
            chk("bp_rdy1", 8'(rdy1), 8'd0);
            chk("bp_f", 8'(f), 8'h0e);
            chk("bp_valid", 8'(ov), 8'd1);
            step();
        end
        w1 = 4'b1110;
        dn_rdy = 1'b1;
        #1;
        chk("bp_rel_rdy0", 8'(rdy0), 8'd1);
        chk("bp_rel_rdy1", 8'(rdy1), 8'd0);
        step();
        chk("bp_rel_f", 8'(f), 8'h05);
        chk("bp_rel_sel", 8'(sel), 8'd0);

        // single requester, then drain
        v1 = 1'b0; w0 = 4'b0011; w1 = 4'b1111;
        #1;
        chk("one_rdy0", 8'(rdy0), 8'd1);
        chk("one_rdy1", 8'(rdy1), 8'd0);
        step();
        chk("one_f", 8'(f), 8'h03);
        chk("one_valid", 8'(ov), 8'd1);
        v0 = 1'b0;
        #1;
        chk("idle_rdy0", 8'(rdy0), 8'd0);
        step();
        chk("drain_valid", 8'(ov), 8'd0);
        chk("drain_f", 8'(f), 8'h03);
        chk("drain_sel", 8'(sel), 8'd0);

        // reset while busy
        v0 = 1'b1; w0 = 4'b0101; dn_rdy = 1'b0;
        step();
        v0 = 1'b0;
        chk("busy_valid", 8'(ov), 8'd1);
        chk("busy_f", 8'(f), 8'h05);
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", 8'({rdy1, rdy0}), 8'd0);
        step();
        chk("mid_rst_valid", 8'(ov), 8'd0);
        chk("mid_rst_f", 8'(f), 8'd0);
        rst = 1'b0; v0 = 1'b1; v1 = 1'b1; dn_rdy = 1'b1;
        #1;
        chk("post_rst_rdy0", 8'(rdy0), 8'd1);
        chk("post_rst_rdy1", 8'(rdy1), 8'd0);

`ifdef MUX_ARB_STATS_EN
        // saturating counters, CNT_W=2
        rst = 1'b1;
        step();
        rst = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("cnt0", 8'(cnt0), (i < 3) ? 8'(i + 1) : 8'd3);
            chk("cnt1", 8'(cnt1), 8'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
